// File: rtl/alu_interface.sv
// Serial-to-ALU bridge: collects A, B and Op from a receiver, runs the ALU,
// and returns the result word followed by a {overflow, zero} status word.
module alu_interface #(
  parameter int N    = 8,
  parameter int NSel = 6
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [N-1:0]    i_rx_data,
  input  logic            i_rx_done,
  input  logic [N-1:0]    i_alu_result,
  input  logic            i_alu_overflow,
  input  logic            i_alu_zero,
  input  logic            i_tx_done,
  output logic [N-1:0]    o_alu_A,
  output logic [N-1:0]    o_alu_B,
  output logic [NSel-1:0] o_alu_Op,
  output logic [N-1:0]    o_tx_data,
  output logic            o_tx_start,
  output logic            o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_CAPTURE,
    S_SEND_RES,
    S_SEND_FLG
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_ovf;
  logic r_zero;
  logic r_tx_start;

  logic w_ld_a;
  logic w_ld_b;
  logic w_ld_op;
  logic w_ld_res;
  logic w_ld_flg;
  logic w_start;
  logic w_tx_ack;
  logic [N-1:0] w_status;

  // A done strobe in the same cycle as our start pulse cannot belong
  // to the word just requested, so it is not taken as an acknowledge.
  assign w_tx_ack = i_tx_done & ~r_tx_start;

  always_comb begin
    w_status    = '0;
    w_status[1] = r_ovf;
    w_status[0] = r_zero;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ld_a   = 1'b0;
    w_ld_b   = 1'b0;
    w_ld_op  = 1'b0;
    w_ld_res = 1'b0;
    w_ld_flg = 1'b0;
    w_start  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_rx_done) begin
          w_ld_a = 1'b1;
          w_next = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (i_rx_done) begin
          w_ld_b = 1'b1;
          w_next = S_WAIT_OP;
        end
      end
      S_WAIT_OP: begin
        if (i_rx_done) begin
          w_ld_op = 1'b1;
          w_next  = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_ld_res = 1'b1;
        w_start  = 1'b1;
        w_next   = S_SEND_RES;
      end
      S_SEND_RES: begin
        if (w_tx_ack) begin
          w_ld_flg = 1'b1;
          w_start  = 1'b1;
          w_next   = S_SEND_FLG;
        end
      end
      S_SEND_FLG: begin
        if (w_tx_ack) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_alu_A    <= '0;
      o_alu_B    <= '0;
      o_alu_Op   <= '0;
      o_tx_data  <= '0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= w_start;
      if (w_ld_a) begin
        o_alu_A <= i_rx_data;
      end
      if (w_ld_b) begin
        o_alu_B <= i_rx_data;
      end
      if (w_ld_op) begin
        o_alu_Op <= i_rx_data[NSel-1:0];
      end
      if (w_ld_res) begin
        o_tx_data <= i_alu_result;
        r_ovf     <= i_alu_overflow;
        r_zero    <= i_alu_zero;
      end
      if (w_ld_flg) begin
        o_tx_data <= w_status;
      end
    end
  end

  assign o_tx_start = r_tx_start;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_interface.sv
// Bench for alu_interface: directed and random transactions against a
// registered reference ALU and an arithmetic model of the returned words.
module tb_alu_interface;

  localparam int N    = 8;
  localparam int NSel = 6;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    i_rx_data;
  logic            i_rx_done;
  logic [N-1:0]    m_res;
  logic            m_ovf;
  logic            m_zero;
  logic            i_tx_done;
  logic [N-1:0]    o_alu_A;
  logic [N-1:0]    o_alu_B;
  logic [NSel-1:0] o_alu_Op;
  logic [N-1:0]    o_tx_data;
  logic            o_tx_start;
  logic            o_busy;

  int vectors     = 0;
  int miscompares = 0;
  int starts      = 0;
  int consec      = 0;
  logic prev_start = 1'b0;

  alu_interface #(.N(N), .NSel(NSel)) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_rx_data      (i_rx_data),
    .i_rx_done      (i_rx_done),
    .i_alu_result   (m_res),
    .i_alu_overflow (m_ovf),
    .i_alu_zero     (m_zero),
    .i_tx_done      (i_tx_done),
    .o_alu_A        (o_alu_A),
    .o_alu_B        (o_alu_B),
    .o_alu_Op       (o_alu_Op),
    .o_tx_data      (o_tx_data),
    .o_tx_start     (o_tx_start),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {overflow, zero, result}; signed overflow from plain integers.
  function automatic logic [9:0] alu_ref(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [5:0] op
  );
    int sa;
    int sb;
    int s;
    logic [7:0] r;
    logic o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = 0;
    o  = 1'b0;
    case (op)
      6'h20: begin s = sa + sb; r = 8'(s); o = (s > 127) || (s < -128); end
      6'h22: begin s = sa - sb; r = 8'(s); o = (s > 127) || (s < -128); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      default: r = 8'h00;
    endcase
    return {o, (r == 8'h00), r};
  endfunction

  always @(posedge clk) begin
    {m_ovf, m_zero, m_res} <= alu_ref(o_alu_A, o_alu_B, o_alu_Op);
  end

  always @(posedge clk) begin
    if (o_tx_start) starts <= starts + 1;
    if (o_tx_start && prev_start) consec <= consec + 1;
    prev_start <= o_tx_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx(input logic [7:0] d);
    @(negedge clk);
    i_rx_data = d;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic tx_ack();
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] opb, input int dly, input bit drop);
    logic [9:0] ref_w;
    logic [7:0] stat;
    int lat;
    int s0;
    int bad;
    ref_w = alu_ref(a, b, opb[5:0]);
    stat  = {6'b0, ref_w[9:8]};
    s0    = starts;
    rx(a);
    chk("load_A", o_alu_A, a);
    chk("busy", o_busy, 1'b1);
    rx(b);
    chk("load_B", o_alu_B, b);
    rx(opb);
    chk("load_Op", o_alu_Op, opb[5:0]);
    lat = 0;
    while (!o_tx_start && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    chk("result_word", o_tx_data, ref_w[7:0]);
    if (drop) begin
      rx(8'hAA);
      chk("drop_A", o_alu_A, a);
      chk("drop_busy", o_busy, 1'b1);
    end
    bad = 0;
    repeat (dly) begin
      @(negedge clk);
      if (o_tx_start || o_tx_data !== ref_w[7:0]) bad++;
    end
    chk("hold_result", bad, 0);
    tx_ack();
    chk("status_word", o_tx_data, stat);
    chk("status_start", o_tx_start, 1'b1);
    bad = 0;
    repeat (dly) begin
      @(negedge clk);
      if (o_tx_start || o_tx_data !== stat) bad++;
    end
    chk("hold_status", bad, 0);
    tx_ack();
    chk("idle", o_busy, 1'b0);
    chk("status_kept", o_tx_data, stat);
    @(negedge clk);
    chk("pulses", starts - s0, 2);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [6];
    int s0;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    rst_n     = 1'b0;
    i_rx_data = '0;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_A", o_alu_A, 0);
    chk("rst_B", o_alu_B, 0);
    chk("rst_Op", o_alu_Op, 0);
    chk("rst_data", o_tx_data, 0);
    chk("rst_start", o_tx_start, 0);
    chk("rst_busy", o_busy, 0);
    rst_n = 1'b1;

    tx_ack();
    chk("txdone_idle", o_busy, 1'b0);

    txn(8'h05, 8'h03, 8'h20, 2, 1'b0);
    txn(8'h03, 8'h03, 8'h22, 1, 1'b0);
    txn(8'h7F, 8'h01, 8'h20, 3, 1'b0);
    txn(8'h10, 8'h20, 8'h20, 2, 1'b1);
    txn(8'h0F, 8'h0F, 8'h25, 1, 1'b0);

    rx(8'h11);
    rx(8'h22);
    s0 = starts;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_A", o_alu_A, 0);
    chk("arst_B", o_alu_B, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_start", o_tx_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_nostart", starts - s0, 0);
    txn(8'h01, 8'h01, 8'h20, 2, 1'b0);

    txn(8'hF0, 8'h3C, 8'hE4, 50, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [7:0] ro;
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = {2'($urandom), ops[$urandom_range(0, 5)]};
      txn(ra, rb, ro, $urandom_range(1, 6), 1'($urandom));
    end

    chk("no_back_to_back", consec, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_interface.md
ALU_INTERFACE -- requirements
Module: alu_interface

Interface
REQ-001 Parameter N, default 8: operand/result width and byte width of the receive and transmit data paths; N SHALL be at least 2.
REQ-002 Parameter NSel, default 6: ALU operation code width; NSel SHALL be at most N.
REQ-003 i_clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_reset  in  1  reset, asynchronous and active-low.
REQ-005 i_rx_data  in  N  received word; valid only while i_rx_done=1.
REQ-006 i_rx_done  in  1  one-cycle strobe marking a new received word.
REQ-007 i_alu_result  in  N  registered ALU result.
REQ-008 i_alu_overflow  in  1  ALU overflow flag.
REQ-009 i_alu_zero  in  1  ALU zero flag.
REQ-010 i_tx_done  in  1  one-cycle strobe; transmitter finished the current word.
REQ-011 o_alu_A  out  N  operand A to ALU.
REQ-012 o_alu_B  out  N  operand B to ALU.
REQ-013 o_alu_Op  out  NSel  operation code to ALU.
REQ-014 o_tx_data  out  N  word to transmit; held stable from o_tx_start until i_tx_done.
REQ-015 o_tx_start  out  1  one-cycle request to transmit o_tx_data.
REQ-016 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-017 Operation: sequence the ALU as initiator: receive A, B, Op in that order; wait out ALU latency; transmit result word, then status word.
REQ-018 States: IDLE, WAIT_B, WAIT_OP, EXEC, CAPTURE, SEND_RES, SEND_FLG.
REQ-019 IDLE: on i_rx_done, load o_alu_A <= i_rx_data; go to WAIT_B.
REQ-020 WAIT_B: on i_rx_done, load o_alu_B <= i_rx_data; go to WAIT_OP.
REQ-021 WAIT_OP: on i_rx_done, load o_alu_Op <= i_rx_data[NSel-1:0] (upper bits discarded); go to EXEC.
REQ-022 EXEC: lasts exactly one cycle, unconditionally, so the ALU registers its result on this edge; go to CAPTURE.
REQ-023 CAPTURE: lasts one cycle; on its edge:
  - latch i_alu_result, i_alu_overflow, i_alu_zero internally;
  - drive o_tx_data <= latched result;
  - o_tx_start=1 for the following cycle;
  - go to SEND_RES.
REQ-024 SEND_RES: on i_tx_done, set o_tx_data <= status word {N-2 zeros, overflow, zero} and pulse o_tx_start for one cycle; go to SEND_FLG.
REQ-025 SEND_FLG: on i_tx_done, go to IDLE; o_tx_data holds its value.
REQ-026 Latency: from the edge accepting Op to o_tx_start high (first word) SHALL be 2 edges.
REQ-027 Operand stability: o_alu_A, o_alu_B, o_alu_Op SHALL hold their values from load until the next load of the same register; they do not clear on return to IDLE.
REQ-028 Ignored inputs: i_rx_done SHALL be ignored in EXEC, CAPTURE, SEND_RES and SEND_FLG (word dropped, no state change); i_tx_done SHALL be ignored outside SEND_RES and SEND_FLG.
REQ-029 o_tx_start SHALL never be high for two consecutive cycles; it SHALL pulse exactly twice per transaction.
REQ-030 Flag latching: the flags sampled in CAPTURE SHALL be the ones transmitted, regardless of later ALU input changes.

Reset
REQ-031 On i_reset=0, immediately and independent of i_clock:
  - state SHALL go to IDLE;
  - o_alu_A, o_alu_B, o_alu_Op, o_tx_data, internal flag latches SHALL be 0;
  - o_tx_start and o_busy SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no further o_tx_start; after release, the next i_rx_done SHALL be taken as operand A.

Verification
(The bench drives the ALU inputs from a reference ALU model with one-cycle registered latency.)
REQ-033 Add: rx 0x05, 0x03, 0x20 -> o_alu_Op=0x20; o_tx_start 2 edges after the Op edge with o_tx_data=0x08; after i_tx_done, second word=0x00.
REQ-034 Subtract to zero: rx 0x03, 0x03, 0x22, model zero=1 -> words 0x00 then 0x01.
REQ-035 Signed overflow: rx 0x7F, 0x01, 0x20, model overflow=1 -> words 0x80 then 0x02.
REQ-036 Dropped word: extra i_rx_done with 0xAA during SEND_RES -> no state change, o_alu_A unchanged; next transaction starts cleanly from IDLE.
REQ-037 Mid-transaction reset: i_reset=0 while in WAIT_OP (A=0x11, B=0x22 loaded) -> all outputs 0 asynchronously; after release, rx 0x01, 0x01, 0x20 -> word 0x02.
REQ-038 Op truncation and slow transmitter: rx Op byte 0xE4 -> o_alu_Op=0x24; with i_tx_done delayed 50 cycles, o_tx_data holds and o_tx_start pulses once per word.
